// File: rtl/alu_sys_pkg.sv
// Shared definitions for the ALU request sequencer: sequencer state encoding,
// ALU unit-class codes and default widths.
package alu_sys_pkg;

   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_FUN_WIDTH      = 4;
   localparam int DEF_TIMEOUT_CYCLES = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } seq_state_t;

   // Unit class lives in the top two bits of the function code; the
   // sequencer never decodes it, it is here for the ALU side.
   localparam logic [1:0] CLS_ARITH = 2'b00;
   localparam logic [1:0] CLS_LOGIC = 2'b01;
   localparam logic [1:0] CLS_CMP   = 2'b10;
   localparam logic [1:0] CLS_SHIFT = 2'b11;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that did not win last time. Last winner updates only on accept.
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] grant_o
);

   logic last_q;

   always_comb begin
      grant_o = req_i;
      if (req_i == 2'b11) begin
         grant_o = last_q ? 2'b01 : 2'b10;
      end
   end

   // Reset value 1 makes requester 0 win the first tie.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else if (accept_i) begin
         last_q <= grant_o[1];
      end
   end

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one registered-output ALU between two requesters: arbitrate, issue a
// one-cycle ALU_EN, wait for the result or a timeout, pulse the response back.
module alu_req_sequencer
   import alu_sys_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int FUN_WIDTH      = DEF_FUN_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    req0_valid,
   output logic                    req0_ready,
   input  logic [DATA_WIDTH-1:0]   req0_a,
   input  logic [DATA_WIDTH-1:0]   req0_b,
   input  logic [FUN_WIDTH-1:0]    req0_fun,
   input  logic                    req1_valid,
   output logic                    req1_ready,
   input  logic [DATA_WIDTH-1:0]   req1_a,
   input  logic [DATA_WIDTH-1:0]   req1_b,
   input  logic [FUN_WIDTH-1:0]    req1_fun,
   output logic                    rsp0_valid,
   output logic                    rsp1_valid,
   output logic [2*DATA_WIDTH-1:0] rsp_result,
   output logic                    rsp_err,
   output logic                    ALU_EN,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   output logic [DATA_WIDTH-1:0]   ALU_A,
   output logic [DATA_WIDTH-1:0]   ALU_B,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VALID,
   output logic                    busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   seq_state_t              state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic                    grant_id_q;
   logic                    alu_en_q;
   logic                    rsp0_q;
   logic                    rsp1_q;
   logic                    err_q;
   logic [DATA_WIDTH-1:0]   alu_a_q;
   logic [DATA_WIDTH-1:0]   alu_b_q;
   logic [FUN_WIDTH-1:0]    alu_fun_q;
   logic [2*DATA_WIDTH-1:0] result_q;
   logic [1:0]              grant;
   logic                    idle;
   logic                    accept;

   assign idle   = (state_q == IDLE);
   assign accept = idle & (|grant);
   assign cnt_d  = cnt_q - CNT_W'(1);

   rr_arbiter2 u_arb (
      .clk_i    (CLK),
      .rst_i    (RST),
      .req_i    ({req1_valid, req0_valid}),
      .accept_i (accept),
      .grant_o  (grant)
   );

   // Ready is combinational from state and valids; RST masks it so every
   // output reads 0 while reset is held.
   assign req0_ready = idle & grant[0] & ~RST;
   assign req1_ready = idle & grant[1] & ~RST;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         grant_id_q <= 1'b0;
         alu_en_q   <= 1'b0;
         rsp0_q     <= 1'b0;
         rsp1_q     <= 1'b0;
         err_q      <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_fun_q  <= '0;
         result_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  alu_a_q    <= grant[1] ? req1_a   : req0_a;
                  alu_b_q    <= grant[1] ? req1_b   : req0_b;
                  alu_fun_q  <= grant[1] ? req1_fun : req0_fun;
                  grant_id_q <= grant[1];
                  alu_en_q   <= 1'b1;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               alu_en_q <= 1'b0;
               cnt_q    <= CNT_W'(TIMEOUT_CYCLES);
               state_q  <= WAIT;
            end
            WAIT: begin
               // A result in the last counted cycle still beats the timeout.
               if (ALU_OUT_VALID) begin
                  result_q <= ALU_OUT;
                  err_q    <= 1'b0;
                  rsp0_q   <= ~grant_id_q;
                  rsp1_q   <= grant_id_q;
                  state_q  <= RESP;
               end else begin
                  cnt_q <= cnt_d;
                  if (cnt_d == '0) begin
                     result_q <= '0;
                     err_q    <= 1'b1;
                     rsp0_q   <= ~grant_id_q;
                     rsp1_q   <= grant_id_q;
                     state_q  <= RESP;
                  end
               end
            end
            RESP: begin
               rsp0_q  <= 1'b0;
               rsp1_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ALU_EN     = alu_en_q;
   assign ALU_A      = alu_a_q;
   assign ALU_B      = alu_b_q;
   assign ALU_FUN    = alu_fun_q;
   assign rsp0_valid = rsp0_q;
   assign rsp1_valid = rsp1_q;
   assign rsp_result = result_q;
   assign rsp_err    = err_q;
   assign busy       = ~idle;

endmodule
